// File: rtl/fft_result_reader.sv
// Purpose : unloads a finished FFT frame from the selected ping-pong bank and streams it out.
// Latency : fft_done in cycle 0 -> first rd_en in cycle 1 -> first out_valid in cycle 3; 1 beat/cycle.
// Backpr. : a 2-entry skid FIFO absorbs reads already in flight; rd_en is withheld while FIFO+inflight would exceed 2.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   fft_done, read_sel    : frame-complete pulse and the bank holding the results
//   rd_en, rd_add         : memory read strobe and address (data returns one cycle later)
//   rd_data0, rd_data1    : bank 0 / bank 1 read data, {real, imag}
//   out_data, out_index   : streamed point and its frequency-bin index
//   out_valid, out_ready  : valid/ready handshake; out_last marks bin 2^N-1
//   busy, unload_done     : unload in progress; one-cycle pulse after the last beat is taken
module fft_result_reader #(
  parameter int BIT_WIDTH = 16,
  parameter int N         = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fft_done,
  input  logic                   read_sel,
  output logic                   rd_en,
  output logic [N-1:0]           rd_add,
  input  logic [2*BIT_WIDTH-1:0] rd_data0,
  input  logic [2*BIT_WIDTH-1:0] rd_data1,
  output logic [2*BIT_WIDTH-1:0] out_data,
  output logic [N-1:0]           out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   unload_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic [2*BIT_WIDTH-1:0] dat;
    logic [N-1:0]           idx;
  } beat_t;

  localparam logic [N:0] LAST_ADDR = {1'b0, {N{1'b1}}};

  state_t       state;
  logic         bank;
  logic [N:0]   issue_cnt;
  logic         inflight;
  logic [N-1:0] cap_idx;

  beat_t        fifo_mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   fifo_count;

  beat_t        head;
  logic         pop;
  logic         push;

  always_comb begin
    head      = fifo_mem[rd_ptr];
    out_valid = (fifo_count != 2'd0);
    out_data  = head.dat;
    out_index = head.idx;
    out_last  = out_valid && (head.idx == {N{1'b1}});
    pop       = out_valid && out_ready;
    push      = inflight;
    busy      = (state != IDLE);
    rd_add    = issue_cnt[N-1:0];
    // fifo_count + inflight - pop < 2, rearranged to avoid a subtraction.
    // The pop term lets a read issue in the same cycle the consumer resumes.
    rd_en     = (state == READ) &&
                (({1'b0, fifo_count} + {2'b00, inflight}) < ({2'b00, pop} + 3'd2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bank            <= 1'b0;
      issue_cnt       <= '0;
      inflight        <= 1'b0;
      cap_idx         <= '0;
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      fifo_count      <= 2'd0;
      fifo_mem[0]     <= '0;
      fifo_mem[1]     <= '0;
      unload_done     <= 1'b0;
    end else begin
      inflight    <= rd_en;
      unload_done <= 1'b0;

      // Capture the word returned for the read issued last cycle.
      if (push) begin
        fifo_mem[wr_ptr].dat <= bank ? rd_data1 : rd_data0;
        fifo_mem[wr_ptr].idx <= cap_idx;
        wr_ptr               <= ~wr_ptr;
        cap_idx              <= cap_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase

      if (rd_en) begin
        issue_cnt <= issue_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (fft_done) begin
            state     <= READ;
            bank      <= read_sel;
            issue_cnt <= '0;
            cap_idx   <= '0;
          end
        end
        READ: begin
          if (rd_en && (issue_cnt == LAST_ADDR)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state       <= IDLE;
            unload_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
